// File: rtl/servo_pwm_multi_if.sv
// Avalon-MM slave bus bundle for the multi-channel servo PWM block.
// The host side uses the master modport and the PWM block uses the slave modport.
interface servo_pwm_multi_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] avs_address;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic              avs_read;
    logic [31:0]       avs_readdata;

    modport master (
        output avs_address,
        output avs_write,
        output avs_writedata,
        output avs_read,
        input  avs_readdata
    );

    modport slave (
        input  avs_address,
        input  avs_write,
        input  avs_writedata,
        input  avs_read,
        output avs_readdata
    );
endinterface

// File: rtl/servo_pwm_multi.sv
// NUM_CH servo PWM outputs driven from one shared frame counter. Width and enable
// writes land in shadow registers and are copied (clamped) to the active set at each frame wrap.
module servo_pwm_multi #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 20,
    parameter int PERIOD_TICKS = 1000000,
    parameter int MIN_TICKS    = 50000,
    parameter int MAX_TICKS    = 100000,
    parameter int ADDR_W       = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    servo_pwm_multi_if.slave  avs,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              frame_tick
);
    localparam logic [CNT_W-1:0] MIN_W    = CNT_W'(MIN_TICKS);
    localparam logic [CNT_W-1:0] MAX_W    = CNT_W'(MAX_TICKS);
    localparam logic [CNT_W-1:0] MID_W    = CNT_W'((MIN_TICKS + MAX_TICKS) / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD_TICKS - 1);
    localparam int               EN_ADDR   = NUM_CH;
    localparam int               FCNT_ADDR = NUM_CH + 1;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  shadow_w_q [NUM_CH];
    logic [CNT_W-1:0]  shadow_w_d [NUM_CH];
    logic [CNT_W-1:0]  active_w_q [NUM_CH];
    logic [CNT_W-1:0]  active_w_d [NUM_CH];
    logic [NUM_CH-1:0] shadow_en_q, shadow_en_d;
    logic [NUM_CH-1:0] active_en_q, active_en_d;
    logic [31:0]       frame_cnt_q, frame_cnt_d;
    logic              frame_tick_q, frame_tick_d;
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       rdata_mux;
    logic              wrap;
    int                addr;

    function automatic logic [CNT_W-1:0] clamp(input logic [CNT_W-1:0] x);
        if (x < MIN_W)      return MIN_W;
        else if (x > MAX_W) return MAX_W;
        else                return x;
    endfunction

    assign addr = int'(avs.avs_address);
    assign wrap = (cnt_q == LAST_CNT);

    // Upper write-data bits beyond the width registers carry no meaning.
    if (CNT_W < 32) begin : g_wdata_unused
        logic unused_wdata;
        assign unused_wdata = ^avs.avs_writedata[31:CNT_W];
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        cnt_d        = wrap ? '0 : cnt_q + 1'b1;
        shadow_en_d  = shadow_en_q;
        active_en_d  = active_en_q;
        frame_cnt_d  = frame_cnt_q + (wrap ? 32'd1 : 32'd0);
        frame_tick_d = wrap;
        rdata_mux    = '0;

        for (int i = 0; i < NUM_CH; i++) begin
            shadow_w_d[i] = shadow_w_q[i];
            active_w_d[i] = active_w_q[i];
            pwm_d[i]      = active_en_q[i] && (cnt_q < active_w_q[i]);
            if (wrap) active_w_d[i] = clamp(shadow_w_q[i]);
            if (avs.avs_write && addr == i) shadow_w_d[i] = avs.avs_writedata[CNT_W-1:0];
            if (addr == i) rdata_mux = 32'(shadow_w_q[i]);
        end

        // The active load above reads the pre-write shadow, so a write on the wrap edge waits a frame.
        if (wrap) active_en_d = shadow_en_q;
        if (avs.avs_write && addr == EN_ADDR) shadow_en_d = avs.avs_writedata[NUM_CH-1:0];

        if (addr == EN_ADDR)   rdata_mux = 32'(shadow_en_q);
        if (addr == FCNT_ADDR) rdata_mux = frame_cnt_q;

        rdata_d = avs.avs_read ? rdata_mux : rdata_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q        <= '0;
            shadow_en_q  <= '0;
            active_en_q  <= '0;
            frame_cnt_q  <= '0;
            frame_tick_q <= 1'b0;
            pwm_q        <= '0;
            rdata_q      <= '0;
            // NOTE: width registers are discrete flops, not RAM, so each entry is reset.
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_w_q[i] <= MID_W;
                active_w_q[i] <= MID_W;
            end
        end else begin
            cnt_q        <= cnt_d;
            shadow_en_q  <= shadow_en_d;
            active_en_q  <= active_en_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_tick_q <= frame_tick_d;
            pwm_q        <= pwm_d;
            rdata_q      <= rdata_d;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_w_q[i] <= shadow_w_d[i];
                active_w_q[i] <= active_w_d[i];
            end
        end
    end

    assign avs.avs_readdata = rdata_q;
    assign pwm_out          = pwm_q;
    assign frame_tick       = frame_tick_q;
endmodule

// File: tb/tb_servo_pwm_multi.sv
// Scoreboard bench for servo_pwm_multi: stimulus queues expected reads and per-frame pulse
// widths; a negedge monitor measures the bus and pulse outputs and pops expectations.
module tb_servo_pwm_multi;
    localparam int NUM_CH = 2;
    localparam int CNT_W  = 8;
    localparam int PERIOD = 100;
    localparam int MIN_T  = 10;
    localparam int MAX_T  = 20;
    localparam int ADDR_W = 3;
    localparam int MID    = 15;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NUM_CH-1:0] pwm_out;
    logic              frame_tick;

    servo_pwm_multi_if #(.ADDR_W(ADDR_W)) bus ();

    servo_pwm_multi #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PERIOD_TICKS(PERIOD),
        .MIN_TICKS(MIN_T), .MAX_TICKS(MAX_T), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .avs(bus),
        .pwm_out(pwm_out),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       exp;
    } rd_exp_t;

    typedef struct {
        int frame;
        int ch;
        int width;
    } pulse_exp_t;

    rd_exp_t    rd_q[$];
    pulse_exp_t pulse_q[$];
    int         vectors = 0;
    int         miscompares = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Monitor state
    int         frame_id = 0;
    int         idx = 0;
    bit         in_frame = 1'b0;
    bit         rd_pending = 1'b0;
    int         hi_cnt [NUM_CH];
    int         first_hi [NUM_CH];
    int         last_hi [NUM_CH];
    rd_exp_t    re;
    pulse_exp_t pe;

    always @(negedge clk) begin
        if (!reset_n) begin
            frame_id   = 0;
            idx        = 0;
            in_frame   = 1'b0;
            rd_pending = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                hi_cnt[c] = 0; first_hi[c] = -1; last_hi[c] = -1;
            end
        end else begin
            if (rd_pending) begin
                if (rd_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected read: got %0d expected no read", bus.avs_readdata);
                end else begin
                    re = rd_q.pop_front();
                    check($sformatf("read addr %0d", re.addr), bus.avs_readdata, re.exp);
                end
            end
            rd_pending = bus.avs_read;

            if (frame_tick) begin
                if (in_frame) begin
                    check("frame period", 32'(idx), 32'(PERIOD));
                    while (pulse_q.size() > 0 && pulse_q[0].frame <= frame_id) begin
                        pe = pulse_q.pop_front();
                        if (pe.frame < frame_id) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL frame%0d ch%0d: got no measurement expected width %0d",
                                     pe.frame, pe.ch, pe.width);
                        end else begin
                            check($sformatf("frame%0d ch%0d width", pe.frame, pe.ch),
                                  32'(hi_cnt[pe.ch]), 32'(pe.width));
                            if (pe.width > 0) begin
                                check($sformatf("frame%0d ch%0d rise", pe.frame, pe.ch),
                                      32'(first_hi[pe.ch]), 32'd1);
                                check($sformatf("frame%0d ch%0d fall", pe.frame, pe.ch),
                                      32'(last_hi[pe.ch]), 32'(pe.width));
                            end
                        end
                    end
                end
                frame_id++;
                idx      = 0;
                in_frame = 1'b1;
                for (int c = 0; c < NUM_CH; c++) begin
                    hi_cnt[c] = 0; first_hi[c] = -1; last_hi[c] = -1;
                end
            end

            for (int c = 0; c < NUM_CH; c++) begin
                if (pwm_out[c]) begin
                    if (hi_cnt[c] == 0) first_hi[c] = idx;
                    hi_cnt[c]++;
                    last_hi[c] = idx;
                end
            end
            idx++;
        end
    end

    task automatic avs_wr(input int addr, input int data);
        @(posedge clk); #1;
        bus.avs_address   = ADDR_W'(addr);
        bus.avs_writedata = 32'(data);
        bus.avs_write     = 1'b1;
        @(posedge clk); #1;
        bus.avs_write     = 1'b0;
    endtask

    task automatic avs_rd(input int addr, input int exp);
        @(posedge clk); #1;
        bus.avs_address = ADDR_W'(addr);
        bus.avs_read    = 1'b1;
        rd_q.push_back('{ADDR_W'(addr), 32'(exp)});
        @(posedge clk); #1;
        bus.avs_read    = 1'b0;
    endtask

    // Returns 1ns after the negedge of the cycle in which frame_tick is high (cnt == 0).
    task automatic wait_tick();
        bit seen = 1'b0;
        for (int i = 0; i < 3 * PERIOD && !seen; i++) begin
            @(negedge clk);
            seen = frame_tick;
        end
        #1;
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL frame_tick timeout: got none expected one within %0d cycles", 3 * PERIOD);
        end
    endtask

    task automatic push_frame(input int frame, input int w0, input int w1);
        pulse_q.push_back('{frame, 0, w0});
        pulse_q.push_back('{frame, 1, w1});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion expected finish within 300000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.avs_address   = '0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = '0;
        bus.avs_read      = 1'b0;
        reset_n           = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset pwm_out", 32'(pwm_out), 32'd0);
        check("reset frame_tick", 32'(frame_tick), 32'd0);
        check("reset readdata", bus.avs_readdata, 32'd0);
        reset_n = 1'b1;

        // Reset values, three idle frames, frame counter
        avs_rd(0, MID);
        avs_rd(1, MID);
        avs_rd(2, 0);
        avs_rd(3, 0);
        wait_tick();
        push_frame(frame_id, 0, 0);
        wait_tick();
        push_frame(frame_id, 0, 0);
        wait_tick();
        push_frame(frame_id, 0, 0);
        avs_rd(3, 3);

        // In-range widths, both enabled
        avs_wr(0, 12);
        avs_wr(1, 18);
        avs_wr(2, 3);
        wait_tick();
        push_frame(frame_id, 12, 18);
        wait_tick();

        // Out-of-range widths read back raw and pulse clamped
        avs_wr(0, 5);
        avs_wr(1, 200);
        avs_rd(0, 5);
        avs_rd(1, 200);
        wait_tick();
        push_frame(frame_id, MIN_T, MAX_T);

        // Write landing on the wrap edge is deferred one frame
        avs_wr(0, 12);
        wait_tick();
        push_frame(frame_id, 12, MAX_T);
        repeat (PERIOD - 1) @(posedge clk);
        #1;
        bus.avs_address   = ADDR_W'(0);
        bus.avs_writedata = 32'd17;
        bus.avs_write     = 1'b1;
        @(posedge clk); #1;
        bus.avs_write     = 1'b0;
        wait_tick();
        push_frame(frame_id, 12, MAX_T);
        avs_rd(0, 17);
        wait_tick();
        push_frame(frame_id, 17, MAX_T);

        // Disable ch0 mid-pulse: current pulse completes, next frame is dark
        repeat (5) @(posedge clk);
        #1;
        check("ch0 high before disable", 32'(pwm_out[0]), 32'd1);
        avs_wr(2, 2);
        wait_tick();
        push_frame(frame_id, 0, MAX_T);
        wait_tick();

        // Asynchronous reset mid-pulse
        repeat (5) @(posedge clk);
        #3;
        check("pwm before reset", 32'(pwm_out), 32'd2);
        reset_n = 1'b0;
        #1;
        check("pwm in async reset", 32'(pwm_out), 32'd0);
        check("frame_tick in async reset", 32'(frame_tick), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        avs_rd(0, MID);
        avs_rd(1, MID);
        avs_rd(2, 0);
        avs_rd(3, 0);
        wait_tick();
        push_frame(frame_id, 0, 0);
        wait_tick();
        repeat (3) @(posedge clk);
        #1;

        check("pulse queue drained", 32'(pulse_q.size()), 32'd0);
        check("read queue drained", 32'(rd_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/servo_pwm_multi.md
Name: servo_pwm_multi

Overview:
Multi-channel servo PWM generator with an Avalon-MM slave register interface. It is the successor to the single-output servo PWM component in the HPS/FPGA system. It drives NUM_CH independent servo pulses from one shared frame counter. Pulse-width and enable updates are double-buffered and applied only at frame boundaries, so no runt or stretched pulses reach a servo. Widths are clamped to a safe range, and a per-frame tick output is provided for HPS/IRQ pacing.

Parameters:
NUM_CH, 4, number of PWM channels (1..16)
CNT_W, 20, width of frame counter and pulse-width registers
PERIOD_TICKS, 1000000, frame length in clk cycles (20 ms at 50 MHz); must be < 2^CNT_W
MIN_TICKS, 50000, minimum active pulse width in cycles (1.0 ms)
MAX_TICKS, 100000, maximum active pulse width in cycles (2.0 ms); MIN_TICKS <= MAX_TICKS < PERIOD_TICKS
ADDR_W, 5, Avalon word-address width; must satisfy 2^ADDR_W >= NUM_CH+2

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
avs_address  input  ADDR_W  word address
avs_write  input  1  write strobe
avs_writedata  input  32  write data
avs_read  input  1  read strobe
avs_readdata  output  32  read data, valid 1 cycle after avs_read
pwm_out  output  NUM_CH  servo pulse outputs, bit i = channel i
frame_tick  output  1  one-cycle pulse at each frame wrap

Behaviour:
- Register map:
  - addr 0..NUM_CH-1: shadow pulse width ch[i], RW, low CNT_W bits used, upper bits read 0.
  - addr NUM_CH: shadow enable mask, RW, low NUM_CH bits.
  - addr NUM_CH+1: frame counter, RO, 32-bit, wraps 2^32-1 -> 0.
  - Other addresses: reads return 0, writes ignored. Writes to the RO address are ignored.
- Reset (async assert, sync deassert by user):
  - cnt = 0; all shadow and active widths = (MIN_TICKS+MAX_TICKS)/2; shadow and active enable = 0.
  - pwm_out = 0, frame_tick = 0, avs_readdata = 0, frame counter = 0.
- Frame counter cnt:
  - Increments every clk.
  - When cnt == PERIOD_TICKS-1, next cnt = 0 (the wrap cycle).
- Wrap cycle (cnt == PERIOD_TICKS-1), registered at that edge:
  - active_w[i] <= clamp(shadow_w[i]).
  - active_en <= shadow_en.
  - frame_tick <= 1 for exactly one cycle, i.e. frame_tick is high while cnt == 0.
  - frame counter += 1.
- clamp(x) = MIN_TICKS if x < MIN_TICKS; MAX_TICKS if x > MAX_TICKS; else x. Comparison is unsigned on CNT_W bits. Shadow registers keep the raw written value and read back raw.
- Simultaneous Avalon write and wrap on the same edge: the active load uses the shadow value from before the write. The new value takes effect at the next wrap, one frame later.
- Output: pwm_out[i] <= active_en[i] && (cnt < active_w[i]), registered.
  - High for exactly active_w[i] consecutive cycles per frame, starting the cycle after cnt == 0.
  - Period is exactly PERIOD_TICKS cycles.
  - Disabled channels stay low for the whole frame.
- Avalon reads:
  - Fixed read latency 1, no waitrequest.
  - avs_readdata updates only on avs_read cycles and holds otherwise.
  - Read and write in the same cycle: the read returns the pre-write value.
- Mid-operation reset: all outputs go low immediately (asynchronous). The first post-reset frame begins at cnt = 0 with all channels disabled.

Test Plan:
Bench parameters for all scenarios: NUM_CH=2, PERIOD_TICKS=100, MIN_TICKS=10, MAX_TICKS=20, CNT_W=8, ADDR_W=3.
1. Reset, then read addr 0,1,2,3 -> 15, 15, 0, 0. pwm_out stays 0 for 300 cycles. frame_tick pulses every 100 cycles, and the addr 3 read then returns 3.
2. Write ch0=12, ch1=18, en=3, then wait for the next wrap -> following frame has pwm_out[0] high 12 cycles and pwm_out[1] high 18 cycles, both rising the cycle after frame_tick. Period measured as 100.
3. Write ch0=5 and ch1=200 -> readback 5 and 200 (raw). Measured pulses 10 and 20 cycles (clamped).
4. Write ch0=17 on the exact wrap edge while active=12 -> that frame pulse is 12; the next frame pulse is 17.
5. Clear en bit0 mid-frame while pwm_out[0] is high -> the current pulse completes its full width. Channel 0 is low for the entire next frame; channel 1 is unaffected.
6. Assert reset_n=0 mid-pulse -> pwm_out = 0 in the same cycle with no clock edge. After release, widths read 15, en reads 0, frame counter reads 0.
